weight_rom_stream_ctrl: RTL

Sequencer that streams a weight parameter ROM (2-cycle registered read, `ce`-gated pipeline) onto a valid/ready bus with correct backpressure. It issues ROM addresses only when downstream space is guaranteed and buffers ROM output in a small FIFO. It repeats the full address range for a programmable number of passes and signals completion. It sits between a `*_weight` ROM wrapper and the linear/attention datapath that consumes weight rows.

---
 rtl/weight_stream_pkg.sv | 12 +
 rtl/weight_stream_fifo.sv | 57 +++++
 rtl/weight_rom_stream_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/weight_stream_pkg.sv
// Shared types and defaults for the weight ROM streaming sequencer.
package weight_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int ROM_LATENCY_DEF = 2;

endpackage

// File: rtl/weight_stream_fifo.sv
// Shift-style synchronous FIFO; entry 0 is the registered head seen by the consumer.
module weight_stream_fifo #(
    parameter int DATA_WIDTH = 128,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [CNT_W-1:0]      count
);

    localparam int IDX_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [CNT_W-1:0]      count_r;
    logic [CNT_W-1:0]      wr_pos;
    logic                  pop;
    logic                  push;

    assign pop    = rd_en && (count_r != '0);
    assign push   = wr_en && ((count_r != CNT_W'(FIFO_DEPTH)) || pop);
    // A popping cycle shifts everything down, so the free slot moves down by one.
    assign wr_pos = pop ? (count_r - 1'b1) : count_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else begin
            count_r <= count_r + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
        end else begin
            if (pop) begin
                for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
                    mem[i] <= mem[i+1];
                end
            end
            if (push) begin
                mem[wr_pos[IDX_W-1:0]] <= wr_data;
            end
        end
    end

    assign rd_data  = mem[0];
    assign rd_valid = (count_r != '0);
    assign count    = count_r;

endmodule

// File: rtl/weight_rom_stream_ctrl.sv
// Streams a fixed-latency weight ROM onto a valid/ready bus for a programmable
// number of passes, issuing reads only when the output FIFO has room for them.
module weight_rom_stream_ctrl
    import weight_stream_pkg::*;
#(
    parameter int DATA_WIDTH  = 128,
    parameter int DEPTH       = 576,
    parameter int ADDR_WIDTH  = $clog2(DEPTH) + 1,
    parameter int ROM_LATENCY = ROM_LATENCY_DEF,
    parameter int FIFO_DEPTH  = 4,
    parameter int PASS_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [PASS_WIDTH-1:0] num_passes,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  rom_ce,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    input  logic                  data_out_ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int IN_W  = $clog2(ROM_LATENCY + 1);
    localparam int SUM_W = $clog2(FIFO_DEPTH + ROM_LATENCY + 1) + 1;

    state_e                 state;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [PASS_WIDTH-1:0]  pass_cnt;
    logic [PASS_WIDTH-1:0]  passes;
    logic [ROM_LATENCY-1:0] vld_p;
    logic [IN_W-1:0]        inflight;
    logic [CNT_W-1:0]       fifo_count;
    logic [SUM_W-1:0]       credit_sum;
    logic                   issue;
    logic                   push;
    logic                   pop;
    logic                   last_addr;
    logic                   last_pass;
    logic                   drain_done;

    // Credit counts every read already in the ROM pipe; a same-cycle pop is not credited.
    assign credit_sum = SUM_W'(fifo_count) + SUM_W'(inflight);
    assign issue      = (state == ST_RUN) && (credit_sum < SUM_W'(FIFO_DEPTH));
    assign push       = vld_p[ROM_LATENCY-1];
    assign pop        = data_out_valid && data_out_ready;
    assign last_addr  = (addr == ADDR_WIDTH'(DEPTH - 1));
    assign last_pass  = (pass_cnt == passes - 1'b1);
    assign drain_done = (inflight == '0) &&
                        ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            addr     <= '0;
            pass_cnt <= '0;
            passes   <= '0;
            done     <= 1'b0;
            vld_p    <= '0;
            inflight <= '0;
        end else begin
            done     <= 1'b0;
            // Issue/valid stage: a 1 shifted in here lines up with rom_q ROM_LATENCY cycles later.
            vld_p    <= (vld_p << 1) | ROM_LATENCY'(issue);
            inflight <= inflight + IN_W'(issue) - IN_W'(push);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (num_passes != '0) begin
                            passes   <= num_passes;
                            pass_cnt <= '0;
                            addr     <= '0;
                            state    <= ST_RUN;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (issue) begin
                        if (last_addr) begin
                            addr     <= '0;
                            pass_cnt <= pass_cnt + 1'b1;
                            if (last_pass) begin
                                state <= ST_DRAIN;
                            end
                        end else begin
                            addr <= addr + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_done) begin
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy     = (state != ST_IDLE);
    assign rom_addr = addr;
    assign rom_ce   = 1'b1;

    weight_stream_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (push),
        .wr_data  (rom_q),
        .rd_en    (data_out_ready),
        .rd_data  (data_out),
        .rd_valid (data_out_valid),
        .count    (fifo_count)
    );

endmodule
